muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_iter_datapath.sv | 51 +++++
 rtl/muldiv_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> muldiv unit handshake bundle.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start_e;
    muldiv_op_t      op_e;
    logic [XLEN-1:0] operand_a_e;
    logic [XLEN-1:0] operand_b_e;
    logic            flush_e;
    logic            stall_e;
    logic            done_m;
    logic [XLEN-1:0] result_m;

    modport master (
        output start_e, op_e, operand_a_e, operand_b_e, flush_e,
        input  stall_e, done_m, result_m
    );

    modport slave (
        input  start_e, op_e, operand_a_e, operand_b_e, flush_e,
        output stall_e, done_m, result_m
    );

endinterface

// File: rtl/muldiv_iter_datapath.sv
// Radix-2 shift-add multiply / restoring divide on unsigned magnitudes,
// sharing one adder/subtractor between both operations.
module muldiv_iter_datapath
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0]   b_q;
    logic [XLEN+1:0]   add_x, add_y, add_res;
    logic [2*XLEN-1:0] acc_nxt;

    // Divide compares the 33-bit shifted remainder, so the adder carries two
    // guard bits; bit XLEN+1 is the borrow of the trial subtraction.
    always_comb begin
        add_x   = is_div ? {1'b0, acc[2*XLEN-1:XLEN-1]} : {2'b00, acc[2*XLEN-1:XLEN]};
        add_y   = is_div ? ~{2'b00, b_q} : {2'b00, b_q};
        add_res = add_x + add_y + {{(XLEN+1){1'b0}}, is_div};
        if (is_div) begin
            if (!add_res[XLEN+1])
                acc_nxt = {add_res[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nxt = {add_res[XLEN:0], acc[XLEN-1:1]};
            else
                acc_nxt = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            b_q <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, a_mag};
            b_q <= b_mag;
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, stall and sign
// handling around the shared iterative datapath.
module muldiv_sequencer #(
    parameter int XLEN           = 32,
    parameter bit DIV0_EARLY_OUT = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    import muldiv_pkg::*;

    muldiv_state_t     state, state_nxt;
    logic [4:0]        cnt;
    muldiv_op_t        op_q;
    logic              a_neg_q, b_neg_q, b_zero_q;
    logic [XLEN-1:0]   result_q;

    logic              accept, div0_early, load, step;
    logic              a_neg_e, b_neg_e;
    logic [XLEN-1:0]   a_mag, b_mag, div0_val;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   quo, rem, fix_val;

    assign accept     = (state == ST_IDLE || state == ST_DONE) && bus.start_e && !bus.flush_e;
    assign div0_early = DIV0_EARLY_OUT && op_is_div(bus.op_e) && (bus.operand_b_e == '0);
    assign div0_val   = bus.op_e[1] ? bus.operand_a_e : '1;

    assign a_neg_e = op_a_signed(bus.op_e) & bus.operand_a_e[XLEN-1];
    assign b_neg_e = op_b_signed(bus.op_e) & bus.operand_b_e[XLEN-1];
    assign a_mag   = a_neg_e ? -bus.operand_a_e : bus.operand_a_e;
    assign b_mag   = b_neg_e ? -bus.operand_b_e : bus.operand_b_e;

    muldiv_iter_datapath u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (op_is_div(op_q)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush_e) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: state_nxt = accept ? (div0_early ? ST_DONE : ST_CALC) : ST_IDLE;
                ST_CALC:          if (cnt == 5'd31) state_nxt = ST_FIXUP;
                ST_FIXUP:         state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall_e = 1'b0;
        bus.done_m  = (state == ST_DONE);
        load        = accept && !div0_early;
        step        = (state == ST_CALC);
        if (rst_n) begin
            case (state)
                ST_CALC, ST_FIXUP: bus.stall_e = 1'b1;
                default:           bus.stall_e = accept;
            endcase
        end
    end

    // Results are magnitudes; restore signs here. Divide-by-zero on the
    // iterating path still needs the all-ones quotient forced.
    always_comb begin
        quo  = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
        if (a_neg_q ^ b_neg_q) quo = -acc[XLEN-1:0];
        if (a_neg_q)           rem = -acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = b_zero_q ? '1 : quo;
            default:                      fix_val = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= OP_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                op_q     <= bus.op_e;
                a_neg_q  <= a_neg_e;
                b_neg_q  <= b_neg_e;
                b_zero_q <= (bus.operand_b_e == '0);
            end else if (state == ST_CALC) begin
                cnt <= cnt + 5'd1;
            end
            if (state == ST_FIXUP && !bus.flush_e)
                result_q <= fix_val;
            else if (accept && div0_early)
                result_q <= div0_val;
        end
    end

    assign bus.result_m = result_q;

endmodule
